regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single register-file write port.
//  Shares it between the in-order pipeline WB stage (port A) and the long-latency unit (port B: mul/div, loads).
//  Port B writebacks are buffered in a FIFO. A scoreboard of pending long-latency destinations drives an ID-stage RAW/WAW stall.
//  Sits between WB/long-latency unit and the register file. Feeds its wr_en/wr_addr/wr_data.
// PARAMETERS
//  XLEN          32  data width
//  DEPTH         4   port-B writeback FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  8   cycles FIFO head may wait before stall_req asserts
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous, active-high
//  a_valid     in   1      pipeline WB write request (cannot be back-pressured)
//  a_addr      in   5      WB destination
//  a_data      in   XLEN   WB data
//  b_valid     in   1      long-latency result valid
//  b_ready     out  1      FIFO can accept (= !full)
//  b_addr      in   5      long-latency destination
//  b_data      in   XLEN   long-latency data
//  iss_valid   in   1      ID issuing a long-latency op
//  iss_rd      in   5      its destination
//  iss_ready   out  1      issue allowed (rd not already pending)
//  q_rs1       in   5      ID source 1 query
//  q_rs2       in   5      ID source 2 query
//  raw_stall   out  1      q_rs1 or q_rs2 pending (combinational)
//  stall_req   out  1      ask hazard unit for one WB bubble
//  wr_en       out  1      regfile write enable (registered)
//  wr_addr     out  5      regfile write address (registered)
//  wr_data     out  XLEN   regfile write data (registered)
// BEHAVIOUR
//  Reset: all outputs registered low/zero; FIFO empty; scoreboard clear; starve counter 0. b_ready=1 and iss_ready=1 from the first post-reset cycle.
//  Arbitration, per cycle M:
//   - Port A has absolute priority.
//   - FIFO head is granted only when !a_valid or a_addr==0.
//   - Grant in cycle M -> wr_en/addr/data valid in M+1 (latency 1).
//  x0 handling:
//   - A with addr 0 -> wr_en=0.
//   - FIFO head with addr 0 -> popped, wr_en=0, no scoreboard change.
//  FIFO push: b_valid & b_ready in cycle N. The entry becomes eligible at N+1 (no same-cycle bypass).
//  Full FIFO: b_ready=0; the producer must hold b_valid/b_addr/b_data.
//  Pointers wrap modulo DEPTH. Simultaneous push+pop when full is illegal, because b_ready=0.
//  Scoreboard: busy[31:0], bit 0 hardwired 0.
//   - Set on iss_valid & iss_ready & iss_rd!=0.
//   - Cleared at the edge ending the grant cycle of the matching FIFO head.
//   - Set and clear of the same register in one cycle -> set wins.
//  iss_ready = !busy[iss_rd] (WAW guard); iss_rd==0 always ready.
//  raw_stall = busy[q_rs1] | busy[q_rs2]. Combinational; x0 never stalls.
//  Port A writing a busy register: allowed and written. busy remains set until the FIFO write lands.
//  Starvation:
//   - Counter increments each cycle the FIFO is non-empty and the head is not granted.
//   - Counter resets to 0 on every pop or when the FIFO is empty; it saturates at STARVE_LIMIT.
//   - stall_req = (counter == STARVE_LIMIT), registered. It drops the cycle after the pop.
//  Reset mid-operation: FIFO contents, scoreboard and counter are discarded. wr_en=0 in the cycle after rst is sampled.
// TESTING
//  1. A: x5 <= 0x11 in cycle 0 -> wr_en=1, wr_addr=5, wr_data=0x11 in cycle 1 only.
//  2. iss x7; B x7=0xAB while a_valid=0 -> raw_stall(q_rs1=7) high until B is granted; write in the next cycle; busy[7]=0 after.
//  3. A valid every cycle and B x3 pending -> no B write; stall_req=1 after 8 waiting cycles. First A bubble -> x3 written; stall_req falls.
//  4. Push 4 B results with A busy -> b_ready=0 on the 5th. Drain order x1,x2,x3,x4 with correct data; b_ready returns after the first pop.
//  5. iss x9 while busy[9] -> iss_ready=0. iss x0 -> iss_ready=1, no busy bit. B to x0 -> popped, wr_en=0.
//  6. rst asserted with 3 FIFO entries and busy bits set -> next cycle: wr_en=0, busy=0, b_ready=1, stall_req=0, and no stale writes afterwards.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between WB (A) and a buffered long-latency port (B), with pending-destination scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            raw_stall,
  output logic            stall_req,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]      addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [31:0]     busy_q, busy_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            empty, full, push, pop, a_w;
  logic [4:0]      h_addr;
  assign empty     = cnt_q == '0;
  assign full      = cnt_q == (AW+1)'(DEPTH);
  assign push      = b_valid & ~full;
  assign a_w       = a_valid & |a_addr;
  assign pop       = ~empty & ~a_w;
  assign h_addr    = addr_mem[rp_q];
  assign b_ready   = ~full;
  assign iss_ready = ~busy_q[iss_rd];
  assign raw_stall = busy_q[q_rs1] | busy_q[q_rs2];
  assign stall_req = stall_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  // an x0 head is still popped but never writes; issue set is applied after the clear so it wins
  always_comb begin
    wp_d      = push ? wp_q + 1'b1 : wp_q;
    rp_d      = pop ? rp_q + 1'b1 : rp_q;
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_en_d   = a_w | (pop & |h_addr);
    wr_addr_d = a_w ? a_addr : (wr_en_d ? h_addr : '0);
    wr_data_d = a_w ? a_data : (wr_en_d ? data_mem[rp_q] : '0);
    busy_d    = ((busy_q & ~(pop ? 32'd1 << h_addr : 32'd0))
                | (iss_valid & iss_ready ? 32'd1 << iss_rd : 32'd0)) & ~32'd1;
    starve_d  = (empty | pop) ? '0 : (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    stall_d   = starve_d == SW'(STARVE_LIMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wp_q] <= b_addr;
      data_mem[wp_q] <= b_data;
    end
  end
endmodule
